mem_stage_multicycle: RTL and testbench

Parametrised MIPS data-memory stage and successor to the single-cycle MEM stage. It adds a configurable multi-cycle memory latency with a pipeline stall handshake, sub-word load sign/zero extension, and misaligned-access detection. It also provides a debug-unit read port that returns a per-word dirty bit. It sits between the EX/MEM register and the WB stage, owns the MEM/WB pipeline register and contains its own byte-enabled data RAM.

---
 rtl/mem_stage_multicycle.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage_multicycle.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_multicycle.sv
// mem_stage_multicycle: MIPS MEM stage with configurable access latency and stall handshake,
// sub-word load/store handling, misaligned-access flag and a dirty-bit debug read port.
module mem_stage_multicycle #(
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_DEPTH      = 1024,
  parameter int MEM_LATENCY    = 1,
  parameter int CANT_REGISTROS = 32,
  parameter int ADDR_BITS      = $clog2(RAM_DEPTH) + 2,
  localparam int RD_BITS       = $clog2(CANT_REGISTROS)
) (
  input  logic                  i_clock,
  input  logic                  i_soft_reset,
  input  logic                  i_enable_pipeline,
  input  logic                  i_MemRead,
  input  logic                  i_MemWrite,
  input  logic                  i_RegWrite,
  input  logic                  i_MemtoReg,
  input  logic                  i_halt_detected,
  input  logic [2:0]            i_select_bytes,
  input  logic [RD_BITS-1:0]    i_registro_destino,
  input  logic [DATA_WIDTH-1:0] i_address_ALU,
  input  logic [DATA_WIDTH-1:0] i_data_write_mem,
  input  logic                  i_debug_req,
  input  logic [ADDR_BITS-1:0]  i_address_debug_unit,
  output logic                  o_stall,
  output logic                  o_RegWrite,
  output logic                  o_MemtoReg,
  output logic                  o_halt_detected,
  output logic [RD_BITS-1:0]    o_registro_destino,
  output logic [DATA_WIDTH-1:0] o_data_alu,
  output logic [DATA_WIDTH-1:0] o_data_mem,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_dato_mem_to_debug_unit,
  output logic                  o_debug_valid,
  output logic                  o_bit_sucio_to_debug_unit
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = ADDR_BITS - 2;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LATENCY - 1);
  localparam logic MULTI = (MEM_LATENCY > 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DEBUG} state_t;

  state_t                r_state, w_state_n;
  logic [CW-1:0]         r_cnt, w_cnt_n;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]  r_dirty;
  logic [AW-1:0]         r_dbg_idx;
  logic [AW-1:0]         w_idx;
  logic                  w_req, w_is_byte, w_is_half, w_mis, w_go, w_adv, w_we;
  logic                  w_dbg_start, w_dbg_done;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_word, w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused;

  assign w_unused  = ^{i_address_ALU[DATA_WIDTH-1:ADDR_BITS], i_address_debug_unit[1:0]};
  assign w_idx     = i_address_ALU[ADDR_BITS-1:2];
  assign w_req     = i_MemRead | i_MemWrite;
  assign w_is_byte = i_select_bytes[1:0] == 2'b00;
  assign w_is_half = i_select_bytes[1:0] == 2'b01;
  assign w_mis     = w_req & ((w_is_half & i_address_ALU[0]) |
                              (~w_is_byte & ~w_is_half & |i_address_ALU[1:0]));
  assign w_go      = w_req & ~w_mis;
  // Stall is forced low in reset so a request held across reset cannot freeze earlier stages.
  assign o_stall   = i_soft_reset & (((r_state == IDLE) & w_go & MULTI) |
                                     ((r_state == ACCESS) & (r_cnt != CW'(1))));
  assign w_adv     = i_enable_pipeline & ~o_stall;
  assign w_we      = i_soft_reset & w_adv & i_MemWrite & ~w_mis;

  always_comb begin
    w_be    = w_is_byte ? NB'(1) << i_address_ALU[1:0] :
              w_is_half ? NB'(3) << {i_address_ALU[1], 1'b0} : {NB{1'b1}};
    w_wdata = w_is_byte ? {NB{i_data_write_mem[7:0]}} :
              w_is_half ? {(NB/2){i_data_write_mem[15:0]}} : i_data_write_mem;
  end

  // Old word is read before the edge, so a combined read+write returns pre-store data.
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{i_address_ALU[1:0], 3'b000} +: 8];
  assign w_half = w_word[{i_address_ALU[1], 4'b0000} +: 16];
  assign w_load = w_is_byte ? (i_select_bytes[2] ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                                 : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte}) :
                  w_is_half ? (i_select_bytes[2] ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                                 : {{(DATA_WIDTH-16){w_half[15]}}, w_half}) :
                  w_word;

  always_ff @(posedge i_clock) begin
    if (w_we)
      for (int b = 0; b < NB; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_dbg_start = 1'b0;
    w_dbg_done  = 1'b0;
    case (r_state)
      IDLE:
        if (i_enable_pipeline & w_go & MULTI) begin
          w_state_n = ACCESS;
          w_cnt_n   = LAT_M1;
        end else if (~i_enable_pipeline & i_debug_req) begin
          w_state_n   = DEBUG;
          w_cnt_n     = LAT_M1;
          w_dbg_start = 1'b1;
        end
      ACCESS:
        if (r_cnt == '0) w_state_n = IDLE;
        else if (i_enable_pipeline) begin
          w_cnt_n = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_n = IDLE;
        end
      DEBUG: begin
        if (r_cnt != '0) w_cnt_n = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_state_n  = IDLE;
          w_dbg_done = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dirty   <= '0;
      r_dbg_idx <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_we) r_dirty[w_idx] <= 1'b1;
      if (w_dbg_start) r_dbg_idx <= i_address_debug_unit[ADDR_BITS-1:2];
    end
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      o_RegWrite         <= 1'b0;
      o_MemtoReg         <= 1'b0;
      o_halt_detected    <= 1'b0;
      o_registro_destino <= '0;
      o_data_alu         <= '0;
      o_data_mem         <= '0;
      o_misaligned       <= 1'b0;
    end else if (i_enable_pipeline) begin
      if (w_adv) begin
        o_RegWrite         <= i_RegWrite & ~w_mis;
        o_MemtoReg         <= i_MemtoReg;
        o_halt_detected    <= i_halt_detected;
        o_registro_destino <= i_registro_destino;
        o_data_alu         <= i_address_ALU;
        o_data_mem         <= w_load;
        o_misaligned       <= w_mis;
      end else begin
        o_RegWrite      <= 1'b0;
        o_MemtoReg      <= 1'b0;
        o_halt_detected <= 1'b0;
        o_misaligned    <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      o_dato_mem_to_debug_unit  <= '0;
      o_bit_sucio_to_debug_unit <= 1'b0;
      o_debug_valid             <= 1'b0;
    end else begin
      o_debug_valid <= w_dbg_done;
      if (w_dbg_done) begin
        o_dato_mem_to_debug_unit  <= r_mem[r_dbg_idx];
        o_bit_sucio_to_debug_unit <= r_dirty[r_dbg_idx];
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_multicycle.sv
// tb_mem_stage_multicycle: directed table plus hand sequences for three latencies (1, 3, 4).
module tb_mem_stage_multicycle;
  logic clk = 1'b0;
  logic rst_n, en, mr, mw, rw_i, m2r_i, halt_i, dreq;
  logic [2:0] sel;
  logic [4:0] rd_i;
  logic [31:0] addr, wdata;
  logic [11:0] daddr;
  logic stall [3], rw [3], m2r [3], halt [3], mis [3], dv [3], dirty [3];
  logic [4:0] rd_o [3];
  logic [31:0] alu_o [3], mem_o [3], dd [3];
  int nvec = 0, nerr = 0;

  typedef struct {
    logic mr, mw, rw, halt;
    logic [2:0] sel;
    logic [4:0] rd;
    logic [31:0] addr, wdata;
    logic e_rw, e_mis, chk;
    logic [31:0] e_mem;
  } vec_t;
  vec_t v [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_multicycle #(.MEM_LATENCY(g == 0 ? 1 : g + 2)) u_dut (
      .i_clock(clk), .i_soft_reset(rst_n), .i_enable_pipeline(en),
      .i_MemRead(mr), .i_MemWrite(mw), .i_RegWrite(rw_i), .i_MemtoReg(m2r_i),
      .i_halt_detected(halt_i), .i_select_bytes(sel), .i_registro_destino(rd_i),
      .i_address_ALU(addr), .i_data_write_mem(wdata), .i_debug_req(dreq),
      .i_address_debug_unit(daddr), .o_stall(stall[g]), .o_RegWrite(rw[g]),
      .o_MemtoReg(m2r[g]), .o_halt_detected(halt[g]), .o_registro_destino(rd_o[g]),
      .o_data_alu(alu_o[g]), .o_data_mem(mem_o[g]), .o_misaligned(mis[g]),
      .o_dato_mem_to_debug_unit(dd[g]), .o_debug_valid(dv[g]),
      .o_bit_sucio_to_debug_unit(dirty[g]));
  end

  task automatic clear_inputs();
    mr = 1'b0; mw = 1'b0; rw_i = 1'b0; m2r_i = 1'b0; halt_i = 1'b0; dreq = 1'b0;
    sel = 3'b010; rd_i = 5'd0; addr = 32'h0; wdata = 32'h0; daddr = 12'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    en = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic mem_op(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input logic chk,
                        input logic [31:0] emem);
    mr = r; mw = w; rw_i = r; m2r_i = r; sel = 3'b010; rd_i = 5'd1; addr = a; wdata = wd; en = 1'b1;
    for (int c = 0; c < lat; c++) begin
      #1 check($sformatf("stall L%0d c%0d", lat, c), 32'(stall[d]), 32'(c < lat - 1));
      @(posedge clk);
      #1 check($sformatf("rw L%0d c%0d", lat, c), 32'(rw[d]), 32'((c == lat - 1) ? r : 1'b0));
    end
    if (chk) check($sformatf("load L%0d", lat), mem_o[d], emem);
    clear_inputs();
  endtask

  task automatic dbg_read(input int d, input logic [11:0] a, input logic [31:0] ed,
                          input logic chk_d, input logic edirty);
    int n;
    clear_inputs();
    en = 1'b0; dreq = 1'b1; daddr = a;
    @(posedge clk);
    #1 dreq = 1'b0;
    n = 0;
    while (!dv[d] && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    nvec++;
    if (!dv[d]) begin
      nerr++;
      $display("FAIL dbg %h: o_debug_valid never rose", a);
    end else if ((chk_d && dd[d] !== ed) || dirty[d] !== edirty) begin
      nerr++;
      $display("FAIL dbg %h: data=%h dirty=%b expected data=%h dirty=%b", a, dd[d], dirty[d], ed, edirty);
    end
    @(posedge clk);
    #1 check($sformatf("dbg pulse %h", a), 32'(dv[d]), 32'h0);
  endtask

  initial begin
    //            mr    mw    rw    halt  sel     rd     addr          wdata         e_rw  e_mis chk   e_mem
    v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 5'd0,  32'h00000010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd3,  32'h00000010, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
    v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 5'd0,  32'h00000030, 32'h000080FF, 1'b0, 1'b0, 1'b0, 32'h0});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 5'd4,  32'h00000030, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFF});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 5'd5,  32'h00000030, 32'h0,        1'b1, 1'b0, 1'b1, 32'h000000FF});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 5'd6,  32'h00000030, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFF80FF});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b101, 5'd7,  32'h00000030, 32'h0,        1'b1, 1'b0, 1'b1, 32'h000080FF});
    v.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 5'd8,  32'h00000031, 32'h00001234, 1'b0, 1'b1, 1'b0, 32'h0});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd9,  32'h00000030, 32'h0,        1'b1, 1'b0, 1'b1, 32'h000080FF});
    v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd0,  32'h00000033, 32'h000000AB, 1'b0, 1'b0, 1'b0, 32'h0});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd9,  32'h00000030, 32'h0,        1'b1, 1'b0, 1'b1, 32'hAB0080FF});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 5'd10, 32'h00000033, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFAB});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 5'd10, 32'h00000032, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFAB00});
    v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 5'd0,  32'h00000012, 32'hFFFF5678, 1'b0, 1'b0, 1'b0, 32'h0});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd2,  32'h00000010, 32'h0,        1'b1, 1'b0, 1'b1, 32'h5678BEEF});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b101, 5'd2,  32'h00000012, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00005678});
    v.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 5'd11, 32'h00001234, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd12, 32'h00001010, 32'h0,        1'b1, 1'b0, 1'b1, 32'h5678BEEF});
    v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 5'd0,  32'h00000042, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0});
    v.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd13, 32'h00000010, 32'h00000099, 1'b1, 1'b0, 1'b1, 32'h5678BEEF});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd14, 32'h00000010, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00000099});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b110, 5'd15, 32'h00000030, 32'h0,        1'b1, 1'b0, 1'b1, 32'hAB0080FF});
    v.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 5'd16, 32'h00000010, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00000099});

    clear_inputs();
    en = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset outs", {rw[0], mis[0], dv[0], m2r[0], halt[0], alu_o[0][26:0]}, 32'h0);
    check("reset mem", mem_o[0] | dd[0], 32'h0);
    check("reset stall", 32'(stall[0]), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < v.size(); i++) begin
      logic s;
      mr = v[i].mr; mw = v[i].mw; rw_i = v[i].rw; m2r_i = v[i].mr; halt_i = v[i].halt;
      sel = v[i].sel; rd_i = v[i].rd; addr = v[i].addr; wdata = v[i].wdata; en = 1'b1;
      #1 s = stall[0];
      @(posedge clk);
      #1 nvec++;
      if (s !== 1'b0 || rw[0] !== v[i].e_rw || mis[0] !== v[i].e_mis || m2r[0] !== v[i].mr ||
          halt[0] !== v[i].halt || rd_o[0] !== v[i].rd || alu_o[0] !== v[i].addr ||
          (v[i].chk && mem_o[0] !== v[i].e_mem)) begin
        nerr++;
        $display("FAIL vec%0d: stall=%b rw=%b mis=%b m2r=%b halt=%b rd=%0d alu=%h mem=%h; expected rw=%b mis=%b rd=%0d alu=%h mem=%h",
                 i, s, rw[0], mis[0], m2r[0], halt[0], rd_o[0], alu_o[0], mem_o[0],
                 v[i].e_rw, v[i].e_mis, v[i].rd, v[i].addr, v[i].e_mem);
      end
    end

    dbg_read(0, 12'h010, 32'h00000099, 1'b1, 1'b1);
    dbg_read(0, 12'h040, 32'h0, 1'b0, 1'b0);
    dbg_read(0, 12'h030, 32'hAB0080FF, 1'b1, 1'b1);

    do_reset();
    mem_op(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3, 1'b0, 32'h0);
    mem_op(1, 1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b1, 32'hCAFEF00D);

    do_reset();
    mem_op(2, 1'b0, 1'b1, 32'h50, 32'h11111111, 4, 1'b0, 32'h0);
    do_reset();
    mw = 1'b1; sel = 3'b010; addr = 32'h50; wdata = 32'h22222222; en = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("L4 mid-access stall", 32'(stall[2]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("L4 reset stall", 32'(stall[2]), 32'h0);
    check("L4 reset ctl", {rw[2], mis[2], m2r[2], halt[2], dv[2], rd_o[2]}, 32'h0);
    check("L4 reset data", alu_o[2] | mem_o[2], 32'h0);
    repeat (2) @(posedge clk);
    #1 clear_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1 dbg_read(2, 12'h050, 32'h11111111, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
